// File: rtl/act_buf_pingpong_ctrl_pkg.sv
// Shared constants and types for the activation ping-pong buffer controller.
package act_buf_pingpong_ctrl_pkg;

    // Total activation memory is 2^16 bytes, split into two 2^15-byte halves.
    localparam int ACT_MEM_ADDR_BITS = 16;
    localparam int ADDR_W            = ACT_MEM_ADDR_BITS;
    localparam int BUF_ADDR_W        = ADDR_W - 1;

    // External loader port width.
    localparam int EXT_PORT_W = 32;
    localparam int EXT_W      = EXT_PORT_W;

    // Loaded-word counter: one half holds 2^15/4 = 8192 words.
    localparam int WCNT_W = 14;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(8192);

    // Ownership state of one buffer half.
    typedef enum logic [1:0] {
        BUF_EMPTY     = 2'd0,
        BUF_LOADING   = 2'd1,
        BUF_FULL      = 2'd2,
        BUF_COMPUTING = 2'd3
    } buf_state_t;

endpackage

// File: rtl/act_buf_pingpong_ctrl_if.sv
// Loader / compute / SRAM-write bundle of the ping-pong controller.
// Handshake: a request (load_start, comp_start) is accepted on a rising
// clock edge only when the matching ready (load_ready, comp_ready) is high
// in the same cycle; done strobes are single-cycle and are honoured only
// while the corresponding buffer is owned. ext_wr_valid has no back-pressure.
interface act_buf_pingpong_ctrl_if;
    import act_buf_pingpong_ctrl_pkg::*;

    logic                  flush;
    logic                  load_start;
    logic                  load_done;
    logic                  ext_wr_valid;
    logic [BUF_ADDR_W-1:0] ext_wr_addr;
    logic [EXT_W-1:0]      ext_wr_data;
    logic                  comp_start;
    logic                  comp_done;

    logic                  load_ready;
    logic                  load_busy;
    logic                  load_buf;
    logic                  comp_ready;
    logic                  comp_busy;
    logic                  comp_buf;
    logic                  mem_wr_en;
    logic [ADDR_W-1:0]     mem_wr_addr;
    logic [EXT_W-1:0]      mem_wr_data;
    logic [WCNT_W-1:0]     words_loaded;
    logic                  proto_err;

    // Debug view of the internal state.
    buf_state_t            dbg_state0;
    buf_state_t            dbg_state1;
    logic                  dbg_ld_ptr;
    logic                  dbg_cp_ptr;

    modport master (
        output flush, load_start, load_done, ext_wr_valid, ext_wr_addr,
               ext_wr_data, comp_start, comp_done,
        input  load_ready, load_busy, load_buf, comp_ready, comp_busy,
               comp_buf, mem_wr_en, mem_wr_addr, mem_wr_data, words_loaded,
               proto_err, dbg_state0, dbg_state1, dbg_ld_ptr, dbg_cp_ptr
    );

    modport slave (
        input  flush, load_start, load_done, ext_wr_valid, ext_wr_addr,
               ext_wr_data, comp_start, comp_done,
        output load_ready, load_busy, load_buf, comp_ready, comp_busy,
               comp_buf, mem_wr_en, mem_wr_addr, mem_wr_data, words_loaded,
               proto_err, dbg_state0, dbg_state1, dbg_ld_ptr, dbg_cp_ptr
    );

endinterface

// File: rtl/act_buf_pingpong_ctrl_state.sv
// Ownership FSM of one buffer half: EMPTY -> LOADING -> FULL -> COMPUTING -> EMPTY.
// Event strobes arrive already qualified by the top level.
module act_buf_pingpong_ctrl_state
    import act_buf_pingpong_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush_i,
    input  logic       load_start_i,
    input  logic       load_done_i,
    input  logic       comp_start_i,
    input  logic       comp_done_i,
    output buf_state_t state_o
);

    buf_state_t state_q, state_d;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= BUF_EMPTY;
        else        state_q <= state_d;
    end

    // Next-state: flush wins, otherwise advance on the strobe matching the state.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY:     if (load_start_i) state_d = BUF_LOADING;
                BUF_LOADING:   if (load_done_i)  state_d = BUF_FULL;
                BUF_FULL:      if (comp_start_i) state_d = BUF_COMPUTING;
                BUF_COMPUTING: if (comp_done_i)  state_d = BUF_EMPTY;
                default:       state_d = BUF_EMPTY;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/act_buf_pingpong_ctrl.sv
// Ping-pong sequencer for the activation memory: buffer ownership arbitration,
// registered SRAM write stream and sticky protocol-error flag.
module act_buf_pingpong_ctrl
    import act_buf_pingpong_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    act_buf_pingpong_ctrl_if.slave bus
);

    buf_state_t st0, st1, st_ld, st_cp;

    logic              ld_ptr_q, ld_ptr_d, cp_ptr_q, cp_ptr_d;
    logic              load_buf_q, load_buf_d, comp_buf_q, comp_buf_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [EXT_W-1:0]  wr_data_q, wr_data_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;

    logic any_loading, any_computing, load_ready_w, comp_ready_w;
    logic ld_accept, ld_finish, cp_accept, cp_finish, wr_ok, err_evt;

    // Everything below is decided from registered state only.
    assign any_loading   = (st0 == BUF_LOADING)   || (st1 == BUF_LOADING);
    assign any_computing = (st0 == BUF_COMPUTING) || (st1 == BUF_COMPUTING);
    assign st_ld         = ld_ptr_q ? st1 : st0;
    assign st_cp         = cp_ptr_q ? st1 : st0;
    assign load_ready_w  = (st_ld == BUF_EMPTY) && !any_loading;
    assign comp_ready_w  = (st_cp == BUF_FULL) && !any_computing;

    // Qualified events; flush masks all of them.
    assign ld_accept = !bus.flush && bus.load_start && load_ready_w;
    assign ld_finish = !bus.flush && bus.load_done  && any_loading;
    assign cp_accept = !bus.flush && bus.comp_start && comp_ready_w;
    assign cp_finish = !bus.flush && bus.comp_done  && any_computing;
    assign wr_ok     = !bus.flush && bus.ext_wr_valid && any_loading
                       && (bus.ext_wr_addr[1:0] == 2'b00);

    // Any rejected request or strobe counts as a protocol violation.
    assign err_evt = !bus.flush && (
                       (bus.load_start && !load_ready_w)  ||
                       (bus.load_done  && !any_loading)   ||
                       (bus.comp_start && !comp_ready_w)  ||
                       (bus.comp_done  && !any_computing) ||
                       (bus.ext_wr_valid && (!any_loading || bus.ext_wr_addr[1:0] != 2'b00)));

    act_buf_pingpong_ctrl_state u_buf0 (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (bus.flush),
        .load_start_i (ld_accept && !ld_ptr_q),
        .load_done_i  (ld_finish && !load_buf_q),
        .comp_start_i (cp_accept && !cp_ptr_q),
        .comp_done_i  (cp_finish && !comp_buf_q),
        .state_o      (st0)
    );

    act_buf_pingpong_ctrl_state u_buf1 (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (bus.flush),
        .load_start_i (ld_accept && ld_ptr_q),
        .load_done_i  (ld_finish && load_buf_q),
        .comp_start_i (cp_accept && cp_ptr_q),
        .comp_done_i  (cp_finish && comp_buf_q),
        .state_o      (st1)
    );

    // Next values for pointers, buffer selects, write pipeline, counter and error flag.
    always_comb begin
        ld_ptr_d   = ld_ptr_q ^ ld_finish;
        cp_ptr_d   = cp_ptr_q ^ cp_finish;
        load_buf_d = ld_accept ? ld_ptr_q : load_buf_q;
        comp_buf_d = cp_accept ? cp_ptr_q : comp_buf_q;
        wr_en_d    = wr_ok;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wcnt_d     = wcnt_q;
        err_d      = err_q || err_evt;
        if (wr_ok) begin
            wr_addr_d = {load_buf_q, bus.ext_wr_addr};
            wr_data_d = bus.ext_wr_data;
            if (wcnt_q != WCNT_MAX) wcnt_d = wcnt_q + WCNT_W'(1);
        end
        if (ld_accept) wcnt_d = '0;
        if (bus.flush) begin
            ld_ptr_d = 1'b0;
            cp_ptr_d = 1'b0;
            wcnt_d   = '0;
            wr_en_d  = 1'b0;
        end
    end

    // Register update; reset returns every output to zero at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_ptr_q   <= 1'b0;
            cp_ptr_q   <= 1'b0;
            load_buf_q <= 1'b0;
            comp_buf_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wcnt_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            ld_ptr_q   <= ld_ptr_d;
            cp_ptr_q   <= cp_ptr_d;
            load_buf_q <= load_buf_d;
            comp_buf_q <= comp_buf_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wcnt_q     <= wcnt_d;
            err_q      <= err_d;
        end
    end

    // Ready flags are held low while reset is asserted.
    assign bus.load_ready   = reset && load_ready_w;
    assign bus.comp_ready   = reset && comp_ready_w;
    assign bus.load_busy    = any_loading;
    assign bus.comp_busy    = any_computing;
    assign bus.load_buf     = load_buf_q;
    assign bus.comp_buf     = comp_buf_q;
    assign bus.mem_wr_en    = wr_en_q;
    assign bus.mem_wr_addr  = wr_addr_q;
    assign bus.mem_wr_data  = wr_data_q;
    assign bus.words_loaded = wcnt_q;
    assign bus.proto_err    = err_q;
    assign bus.dbg_state0   = st0;
    assign bus.dbg_state1   = st1;
    assign bus.dbg_ld_ptr   = ld_ptr_q;
    assign bus.dbg_cp_ptr   = cp_ptr_q;

endmodule
